// File: rtl/cache_mem_responder_pkg.sv
// Shared type codes, FSM state encoding and stall-LFSR step for the cache memory responder.
// Pure definitions; no logic, no latency, no flow control.
package cache_mem_responder_pkg;

    localparam logic [2:0] CACHE_RT_BYTE = 3'b000;
    localparam logic [2:0] CACHE_RT_HALF = 3'b001;
    localparam logic [2:0] CACHE_RT_WORD = 3'b010;
    localparam logic [2:0] CACHE_RT_LINE = 3'b100;

    localparam int CACHE_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        CACHE_RESP_IDLE     = 2'd0,
        CACHE_RESP_RD_WAIT  = 2'd1,
        CACHE_RESP_RD_BURST = 2'd2,
        CACHE_RESP_WR_DRAIN = 2'd3
    } resp_state_t;

    localparam logic [15:0] CACHE_RESP_LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16/14/13/11.
    function automatic logic [15:0] resp_lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

endpackage

// File: rtl/cache_mem_responder_sram.sv
// Single-port word-wide RAM with byte write enables; array is not reset.
// Latency: read data registered one edge after i_re. No backpressure.
// Only the output register is reset so the responder's ret_data clears on reset.
module resp_sram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_re,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdat,
    output logic [31:0]   o_rdat
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdat;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdat <= '0;
        end else if (i_re) begin
            r_rdat <= r_mem[i_addr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache rd_*/wr_* traffic; optional beat stalls via CACHE_RESP_STALL_EN.
// Latency: first read beat RD_LAT+1 cycles after accept; line write drains in 4 cycles.
// Backpressure: rd_rdy/wr_rdy high only in IDLE; a simultaneous write wins over a read.
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int MEM_LOG_WORDS = 12,
    parameter int RD_LAT        = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    localparam int         AW       = MEM_LOG_WORDS;
    localparam logic [3:0] LAT_LAST = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

    resp_state_t    r_state, w_next;
    logic [3:0]     r_cnt;
    logic [1:0]     r_idx;
    logic           r_line;
    logic [AW-1:0]  r_word;
    logic [127:0]   r_wdata;
    logic [3:0]     r_wstrb;
    logic           r_ret_valid, r_ret_last;

    logic           w_acc_rd, w_acc_wr, w_stall, w_issue, w_issue_last;
    logic [AW-1:0]  w_ram_addr;
    logic [31:0]    w_ram_wdat;
    logic [3:0]     w_ram_we;
    logic           w_unused;

    assign w_acc_wr = (r_state == CACHE_RESP_IDLE) && wr_req;
    assign w_acc_rd = (r_state == CACHE_RESP_IDLE) && rd_req && !wr_req;
    assign w_unused = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};

`ifdef CACHE_RESP_STALL_EN
    logic [15:0] r_lfsr, w_lfsr_nx;
    assign w_lfsr_nx = resp_lfsr_next(r_lfsr);
    // Gate on the next LFSR value so ret_valid is low in the very cycle bit 0 reads 1.
    assign w_stall   = w_lfsr_nx[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_lfsr <= CACHE_RESP_LFSR_SEED;
        else         r_lfsr <= w_lfsr_nx;
    end
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= CACHE_RESP_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            CACHE_RESP_IDLE: begin
                if (w_acc_wr)      w_next = CACHE_RESP_WR_DRAIN;
                else if (w_acc_rd) w_next = (RD_LAT == 0) ? CACHE_RESP_RD_BURST : CACHE_RESP_RD_WAIT;
            end
            CACHE_RESP_RD_WAIT:  if (r_cnt == LAT_LAST) w_next = CACHE_RESP_RD_BURST;
            CACHE_RESP_RD_BURST: if (r_ret_last) w_next = CACHE_RESP_IDLE;
            CACHE_RESP_WR_DRAIN: if (!r_line || r_idx == 2'd3) w_next = CACHE_RESP_IDLE;
            default:             w_next = CACHE_RESP_IDLE;
        endcase
    end

    always_comb begin
        rd_rdy       = 1'b0;
        wr_rdy       = 1'b0;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        w_ram_we     = 4'h0;
        w_ram_addr   = r_line ? {r_word[AW-1:2], r_idx} : r_word;
        w_ram_wdat   = r_line ? r_wdata[{r_idx, 5'd0} +: 32] : r_wdata[31:0];
        case (r_state)
            CACHE_RESP_IDLE: begin
                wr_rdy       = 1'b1;
                rd_rdy       = !wr_req;
                // Zero-latency reads look up the RAM straight from the request.
                w_ram_addr   = (rd_type == CACHE_RT_LINE) ? {rd_addr[AW+1:4], 2'b00} : rd_addr[AW+1:2];
                w_issue      = (RD_LAT == 0) && w_acc_rd && !w_stall;
                w_issue_last = (rd_type != CACHE_RT_LINE);
            end
            CACHE_RESP_RD_WAIT: begin
                w_issue      = (r_cnt == LAT_LAST) && !w_stall;
                w_issue_last = !r_line;
            end
            CACHE_RESP_RD_BURST: begin
                w_issue      = !r_ret_last && !w_stall;
                w_issue_last = !r_line || (r_idx == 2'd3);
            end
            CACHE_RESP_WR_DRAIN: w_ram_we = r_line ? 4'hF : r_wstrb;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_line      <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
        end else begin
            r_ret_valid <= w_issue;
            r_ret_last  <= w_issue && w_issue_last;
            r_cnt       <= (r_state == CACHE_RESP_RD_WAIT) ? r_cnt + 4'd1 : 4'd0;
            if (r_state == CACHE_RESP_IDLE) begin
                r_idx <= {1'b0, w_issue};
            end else if (w_issue || r_state == CACHE_RESP_WR_DRAIN) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_acc_wr) begin
                r_line  <= (wr_type == CACHE_RT_LINE);
                r_word  <= wr_addr[AW+1:2];
                r_wdata <= wr_data;
                r_wstrb <= wr_wstrb;
            end else if (w_acc_rd) begin
                r_line  <= (rd_type == CACHE_RT_LINE);
                r_word  <= rd_addr[AW+1:2];
            end
        end
    end

    resp_sram #(.AW(AW)) u_sram (
        .clk    (clk),
        .resetn (resetn),
        .i_re   (w_issue),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdat (w_ram_wdat),
        .o_rdat (ret_data)
    );

    assign ret_valid = r_ret_valid;
    assign ret_last  = r_ret_last;

endmodule
